init_read: RTL and testbench

- Read-initiation controller for one router input FIFO.
- Watches the flit ID at the FIFO output and the FIFO empty flag.
- Asserts a read-enable window from a head flit through the matching tail flit, so one whole packet drains before the next starts.
- Sits between the input FIFO and the downstream routing/arbitration logic of the NoC router.

---
 rtl/init_read_pkg.sv | 13 +
 rtl/init_read.sv | 45 ++++
 tb/tb_init_read.sv | 127 ++++++++++++
 3 files changed

// File: rtl/init_read_pkg.sv
// Shared router parameters: flit-ID field width and flit-type encodings used by
// the input FIFO, routing, arbitration and read-initiation blocks.
package init_read_pkg;

    localparam int FLIT_ID_W = 3;

    typedef logic [FLIT_ID_W-1:0] flit_id_t;

    localparam flit_id_t HEAD_ID = 3'b001;
    localparam flit_id_t BODY_ID = 3'b010;
    localparam flit_id_t TAIL_ID = 3'b100;

endpackage

// File: rtl/init_read.sv
// Read-initiation controller for one router input FIFO: holds init_rd high from
// a valid head flit through the matching valid tail flit so packets drain whole.
module init_read
    import init_read_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     empty,
    input  flit_id_t flit_id,
    output logic     init_rd
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!empty && flit_id == HEAD_ID) state_next = READ;
            READ: if (!empty && flit_id == TAIL_ID) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded purely from the state flop; reads while empty are dropped by the FIFO.
    assign init_rd = (state == READ);

endmodule

// File: tb/tb_init_read.sv
// Directed self-checking bench for init_read: each step pushes the expected
// post-edge init_rd to a scoreboard queue and pops it once the edge has passed.
module tb_init_read;
    import init_read_pkg::*;

    logic     clk;
    logic     rst;
    logic     empty;
    flit_id_t flit_id;
    logic     init_rd;

    int checks = 0;
    int passed = 0;

    logic exp_q[$];
    logic last_exp;
    bit   have_last = 1'b0;

    init_read dut (
        .clk     (clk),
        .rst     (rst),
        .empty   (empty),
        .flit_id (flit_id),
        .init_rd (init_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s: init_rd observed %b, expected %b at %0t", tag, obs, exp, $time);
            $error("%s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs away from the active edge, check that init_rd did
    // not react combinationally, then compare the registered result after the edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [2:0] id, input logic exp);
        logic want;
        @(negedge clk);
        rst     = r;
        empty   = e;
        flit_id = id;
        exp_q.push_back(exp);
        if (have_last) begin
            #1;
            compare({tag, "_hold"}, init_rd, last_exp);
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            compare({tag, "_sb_empty"}, 1'bx, exp);
        end else begin
            want = exp_q.pop_front();
            compare(tag, init_rd, want);
            last_exp  = want;
            have_last = 1'b1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        empty   = 1'b1;
        flit_id = 3'd0;

        // Reset for two cycles, then release with nothing in the FIFO
        step("rst0",      1, 1, 3'd0, 0);
        step("rst1",      1, 1, 3'd0, 0);
        step("rel",       0, 1, 3'd0, 0);

        // Sweep every flit_id code with a valid flit
        step("sweep0",    0, 0, 3'd0, 0);
        step("sweep1",    0, 0, 3'd1, 1);
        step("sweep2",    0, 0, 3'd2, 1);
        step("sweep3",    0, 0, 3'd3, 1);
        step("sweep4",    0, 0, 3'd4, 0);
        step("sweep5",    0, 0, 3'd5, 0);
        step("sweep6",    0, 0, 3'd6, 0);
        step("sweep7",    0, 0, 3'd7, 0);

        // Empty gating in both states
        step("idle_emp",  0, 1, 3'd1, 0);
        step("head",      0, 0, 3'd1, 1);
        step("read_emp",  0, 1, 3'd4, 1);
        step("tail",      0, 0, 3'd4, 0);

        // Spurious IDs in IDLE, second head in READ
        step("sp_tail",   0, 0, 3'd4, 0);
        step("sp_3",      0, 0, 3'd3, 0);
        step("sp_7",      0, 0, 3'd7, 0);
        step("head_a",    0, 0, 3'd1, 1);
        step("head_b",    0, 0, 3'd1, 1);
        step("body",      0, 0, 3'd2, 1);
        step("read_6",    0, 0, 3'd6, 1);
        step("tail_a",    0, 0, 3'd4, 0);
        step("tail_b",    0, 0, 3'd4, 0);

        // Back-to-back packets
        step("b2b_h0",    0, 0, 3'd1, 1);
        step("b2b_t0",    0, 0, 3'd4, 0);
        step("b2b_h1",    0, 0, 3'd1, 1);
        step("b2b_b1",    0, 0, 3'd2, 1);
        step("b2b_t1",    0, 0, 3'd4, 0);

        // Reset mid-packet aborts it; body flits afterwards do not restart
        step("mid_head",  0, 0, 3'd1, 1);
        step("mid_rst",   1, 0, 3'd2, 0);
        step("post_b0",   0, 0, 3'd2, 0);
        step("post_b1",   0, 0, 3'd2, 0);

        // Reset dominates a valid head
        step("rst_head",  1, 0, 3'd1, 0);
        step("after",     0, 1, 3'd1, 0);

        if (exp_q.size() != 0) begin
            compare("sb_leftover", 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
